// File: rtl/tt_capture.sv
// ---------------------------------------------------------------------------
// TtCapture (module tt_capture)
//
// Purpose:
//   Sweeps all 128 input vectors of a 7-input combinational function, holds
//   each vector for SETTLE cycles, records the function output into a
//   128-bit truth table, then streams that table out as 32 hex nibbles
//   (most significant nibble first) over a valid/ready handshake.
//
// Optional feature:
//   TT_CAPTURE_POPCOUNT_EN  - when defined, 'ones' counts the 1-samples of
//                             the current capture and equals popcount(tt)
//                             once tt_valid is high. When undefined, 'ones'
//                             is tied to zero and no counter is built.
//
// Parameters:
//   SETTLE     cycles each vector is held before f_in is sampled (1..15)
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   start      capture request, honoured only in IDLE
//   x_drv      vector driven to the function under test (bit k -> xk)
//   f_in       output of the function under test
//   busy       high in every state except IDLE
//   tt         captured truth table, tt[i] = f(i)
//   tt_valid   tt holds a complete capture
//   nib_data   current nibble of the output stream
//   nib_valid  nib_data is valid (high throughout EMIT)
//   nib_ready  downstream accepts the nibble when high with nib_valid
//   nib_last   marks the 32nd nibble
//   done       one-cycle pulse after the last nibble handshake
//   ones       population count of tt (see optional feature)
// ---------------------------------------------------------------------------
module tt_capture #(
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [6:0]   x_drv,
    input  logic         f_in,
    output logic         busy,
    output logic [127:0] tt,
    output logic         tt_valid,
    output logic [3:0]   nib_data,
    output logic         nib_valid,
    input  logic         nib_ready,
    output logic         nib_last,
    output logic         done,
    output logic [7:0]   ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Settle counter value on the cycle in which f_in is sampled.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [6:0] VEC_LAST    = 7'd127;
    localparam logic [4:0] NIB_LAST    = 5'd31;

    state_e         state_q,     state_d;
    logic [6:0]     vecIdx_q,    vecIdx_d;
    logic [3:0]     settleCnt_q, settleCnt_d;
    logic [4:0]     nibIdx_q,    nibIdx_d;
    logic [127:0]   tt_q,        tt_d;
    logic           ttValid_q,   ttValid_d;

    logic           startAccept;
    logic           sampleNow;

    // A start only counts in IDLE; in every other state, DONE included,
    // it is dropped.
    assign startAccept = (state_q == IDLE) && start;

    // The sample edge is the one that closes the SETTLE-th cycle of the
    // current vector.
    assign sampleNow = (state_q == DRIVE) && (settleCnt_q == SETTLE_LAST);

    // State and datapath registers; reset wipes everything, so an aborted
    // capture leaves no trace and produces no nibble or done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vecIdx_q    <= '0;
            settleCnt_q <= '0;
            nibIdx_q    <= '0;
            tt_q        <= '0;
            ttValid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vecIdx_q    <= vecIdx_d;
            settleCnt_q <= settleCnt_d;
            nibIdx_q    <= nibIdx_d;
            tt_q        <= tt_d;
            ttValid_q   <= ttValid_d;
        end
    end

    // Next-state logic. The vector index stops at 127 and is returned to 0
    // when leaving DRIVE, so it never wraps mid-capture. The nibble index
    // only moves on an accepted handshake, which keeps nib_data/nib_last
    // stable through any stall.
    always_comb begin
        state_d     = state_q;
        vecIdx_d    = vecIdx_q;
        settleCnt_d = settleCnt_q;
        nibIdx_d    = nibIdx_q;
        tt_d        = tt_q;
        ttValid_d   = ttValid_q;

        case (state_q)
            IDLE: begin
                if (startAccept) begin
                    state_d     = DRIVE;
                    vecIdx_d    = '0;
                    settleCnt_d = '0;
                    nibIdx_d    = '0;
                    tt_d        = '0;
                    ttValid_d   = 1'b0;
                end
            end

            DRIVE: begin
                if (sampleNow) begin
                    tt_d[vecIdx_q] = f_in;
                    settleCnt_d    = '0;
                    if (vecIdx_q == VEC_LAST) begin
                        state_d   = EMIT;
                        ttValid_d = 1'b1;
                        vecIdx_d  = '0;
                        nibIdx_d  = '0;
                    end else begin
                        vecIdx_d = vecIdx_q + 7'd1;
                    end
                end else begin
                    settleCnt_d = settleCnt_q + 4'd1;
                end
            end

            EMIT: begin
                if (nib_ready) begin
                    if (nibIdx_q == NIB_LAST) begin
                        state_d  = DONE;
                        nibIdx_d = '0;
                    end else begin
                        nibIdx_d = nibIdx_q + 5'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Nibble k covers tt[127-4k -: 4]; its low bit index 124-4k equals
    // 4*(31-k), and 31-k is just the bitwise inverse of the 5-bit index.
    logic [6:0] nibBase;
    assign nibBase = {~nibIdx_q, 2'b00};

    assign busy      = (state_q != IDLE);
    assign x_drv     = (state_q == DRIVE) ? vecIdx_q : 7'd0;
    assign tt        = tt_q;
    assign tt_valid  = ttValid_q;
    assign nib_valid = (state_q == EMIT);
    assign nib_data  = (state_q == EMIT) ? tt_q[nibBase +: 4] : 4'd0;
    assign nib_last  = (state_q == EMIT) && (nibIdx_q == NIB_LAST);
    assign done      = (state_q == DONE);

`ifdef TT_CAPTURE_POPCOUNT_EN
    logic [7:0] ones_q, ones_d;

    // Running count of 1-samples; it tracks tt bit for bit, so it equals
    // popcount(tt) once the sweep completes and holds it afterwards.
    always_comb begin
        ones_d = ones_q;
        if (startAccept) begin
            ones_d = '0;
        end else if (sampleNow && f_in) begin
            ones_d = ones_q + 8'd1;
        end
    end

    // Popcount register, cleared by reset like the rest of the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ones = ones_q;
`else
    assign ones = 8'd0;
`endif

endmodule
